// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Memory port arbiter: access modes, FSM states, owners.
// The optional round-robin policy is selected with MEM_ARB_RR_EN (see mem_arb_pick).
package mem_arb_pkg;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   // Wide enough for any starvation bound up to 15.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_D    = 2'b10
   } owner_e;

   // A new winner may only be picked on the edge leaving IDLE or RESP.
   function automatic logic is_arb_state(input state_e s);
      return (s == ST_IDLE) || (s == ST_RESP);
   endfunction

   function automatic logic mode_legal(input logic [1:0] m);
      return (m == MODE_BYTE) || (m == MODE_HALF) || (m == MODE_WORD);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the Memory port: D priority with an IF starvation bound, or round-robin
// when MEM_ARB_RR_EN is defined. Pure combinational; the top registers the result.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic             if_req_i,
   input  logic             d_req_i,
   input  logic             last_d_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             gnt_if_o,
   output logic             gnt_d_o,
   output logic [CNT_W-1:0] cnt_d_o
);

`ifdef MEM_ARB_RR_EN
   logic unused_cnt;
   assign unused_cnt = ^cnt_i;

   // On contention the requester that was not granted last time wins.
   always_comb begin
      gnt_if_o = 1'b0;
      gnt_d_o  = 1'b0;
      cnt_d_o  = '0;
      if (if_req_i && d_req_i) begin
         gnt_if_o = last_d_i;
         gnt_d_o  = ~last_d_i;
      end else begin
         gnt_if_o = if_req_i;
         gnt_d_o  = d_req_i;
      end
   end
`else
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic force_if;
   logic unused_last;
   assign unused_last = last_d_i;

   assign force_if = if_req_i && (cnt_i == STARVE_LIM);

   // The count tracks consecutive D wins while IF waits; any IF win or idle IF clears it.
   always_comb begin
      gnt_d_o  = d_req_i && !force_if;
      gnt_if_o = if_req_i && !gnt_d_o;
      cnt_d_o  = '0;
      if (gnt_d_o && if_req_i) begin
         cnt_d_o = cnt_i + CNT_W'(1);
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported Memory between IF (read-only) and D (read/write).
// Define MEM_ARB_RR_EN for round-robin arbitration instead of D priority with a starvation bound.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_mode,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output state_e            dbg_state
);

   // Handshake: a requester holds *_req and its address/data stable until *_gnt pulses (it may
   // withdraw before that); *_gnt marks the ACCESS cycle, *_rvalid pulses exactly one cycle later,
   // and a req still high after its rvalid is a fresh request. There is no back-pressure on rvalid.

   state_e            state_q;
   owner_e            owner_q;
   logic              last_d_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              if_gnt_q;
   logic              d_gnt_q;
   logic              if_rvalid_q;
   logic              d_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [1:0]        mem_mode_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              gnt_if_d;
   logic              gnt_d_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              arb_en;

   assign arb_en = is_arb_state(state_q);

   mem_arb_pick #(
      .STARVE_MAX(STARVE_MAX)
   ) u_pick (
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .last_d_i (last_d_q),
      .cnt_i    (cnt_q),
      .gnt_if_o (gnt_if_d),
      .gnt_d_o  (gnt_d_d),
      .cnt_d_o  (cnt_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         last_d_q    <= 1'b1;
         cnt_q       <= '0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_mode_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if (arb_en) begin
            cnt_q       <= cnt_d;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (gnt_if_d) begin
               state_q     <= ST_ACCESS;
               owner_q     <= OWN_IF;
               last_d_q    <= 1'b0;
               if_gnt_q    <= 1'b1;
               mem_read_q  <= 1'b1;
               mem_mode_q  <= MODE_WORD;
               mem_addr_q  <= if_addr;
               mem_wdata_q <= '0;
            end else if (gnt_d_d) begin
               state_q     <= ST_ACCESS;
               owner_q     <= OWN_D;
               last_d_q    <= 1'b1;
               d_gnt_q     <= 1'b1;
               mem_read_q  <= ~d_we;
               mem_write_q <= d_we;
               mem_mode_q  <= d_mode;
               mem_addr_q  <= d_addr;
               mem_wdata_q <= d_wdata;
            end else begin
               state_q <= ST_IDLE;
               owner_q <= OWN_NONE;
            end
         end else if (state_q == ST_ACCESS) begin
            state_q     <= ST_RESP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (!if_req) begin
               cnt_q <= '0;
            end
            // Read data is only captured for reads; a store leaves d_rdata untouched.
            if (owner_q == OWN_IF) begin
               if_rdata_q  <= mem_rdata;
               if_rvalid_q <= 1'b1;
            end else if (owner_q == OWN_D) begin
               d_rvalid_q <= 1'b1;
               if (mem_read_q) begin
                  d_rdata_q <= mem_rdata;
               end
            end
         end else begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
         end
      end
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_mode  = mem_mode_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

   a_one_gnt: assert property (@(posedge clk) disable iff (!rst) !(if_gnt_q && d_gnt_q));
   a_one_rvalid: assert property (@(posedge clk) disable iff (!rst) !(if_rvalid_q && d_rvalid_q));
   a_write_in_access: assert property (@(posedge clk) disable iff (!rst)
      mem_write_q |-> (state_q == ST_ACCESS));
   a_mode_legal: assert property (@(posedge clk) disable iff (!rst)
      (mem_read_q || mem_write_q) |-> mode_legal(mem_mode_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model (honours MEM_ARB_RR_EN).
module tb_mem_port_arbiter
   import mem_arb_pkg::*;
;
   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [5:0]  if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [1:0]  d_mode;
   logic [5:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_read, mem_write;
   logic [1:0]  mem_mode;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        busy;
   state_e      dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset / memory ----------------
   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .dbg_state(dbg_state)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i);
   endfunction

   logic [31:0] mem [64];
   logic        mem_init = 1'b0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (mem_write) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_mode = MODE_WORD; d_addr = '0; d_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      mem_init = 1'b1;
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      rst = 1'b1;
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic        m_in_flight, m_is_d, m_we, m_last_d;
   logic [5:0]  m_addr;
   logic [31:0] m_wdata;
   int          m_streak;
   logic [31:0] mem_m [64];
   logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_read, e_write, e_busy;
   logic [1:0]  e_mode;
   logic [5:0]  e_addr;
   logic [31:0] e_wdata, e_if_rdata, e_d_rdata;

   task automatic model_reset();
      m_in_flight = 0; m_is_d = 0; m_we = 0; m_last_d = 1; m_addr = '0; m_wdata = '0;
      m_streak = 0;
      for (int i = 0; i < 64; i++) mem_m[i] = init_word(i);
      e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_read = 0; e_write = 0; e_busy = 0;
      e_mode = '0; e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
   endtask

   // One rising edge: either the in-flight access completes, or a new access is chosen.
   task automatic model_edge();
      logic take_d, take_if;
      e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0;
      if (m_in_flight) begin
         m_in_flight = 0; e_read = 0; e_write = 0; e_busy = 1;
         if (m_is_d) begin
            e_d_rv = 1;
            if (m_we) mem_m[m_addr] = m_wdata;
            else e_d_rdata = mem_m[m_addr];
         end else begin
            e_if_rv = 1;
            e_if_rdata = mem_m[m_addr];
         end
         if (!if_req) m_streak = 0;
      end else begin
`ifdef MEM_ARB_RR_EN
         take_d = (if_req && d_req) ? !m_last_d : d_req;
`else
         take_d = d_req && !(if_req && m_streak >= STARVE);
`endif
         take_if = if_req && !take_d;
         m_streak = (take_d && if_req) ? m_streak + 1 : 0;
         if (take_d || take_if) begin
            m_in_flight = 1; e_busy = 1; m_is_d = take_d; m_last_d = take_d;
            e_if_gnt = take_if; e_d_gnt = take_d;
            if (take_d) begin
               m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
               e_read = !d_we; e_write = d_we; e_mode = d_mode; e_addr = d_addr; e_wdata = d_wdata;
            end else begin
               m_we = 0; m_addr = if_addr; m_wdata = '0;
               e_read = 1; e_write = 0; e_mode = MODE_WORD; e_addr = if_addr; e_wdata = '0;
            end
         end else begin
            e_busy = 0; e_read = 0; e_write = 0;
         end
      end
   endtask

   task automatic check_all(input string t);
      chk({t, ".gnt"}, 32'({if_gnt, d_gnt}), 32'({e_if_gnt, e_d_gnt}));
      chk({t, ".rvalid"}, 32'({if_rvalid, d_rvalid}), 32'({e_if_rv, e_d_rv}));
      chk({t, ".if_rdata"}, if_rdata, e_if_rdata);
      chk({t, ".d_rdata"}, d_rdata, e_d_rdata);
      chk({t, ".rw"}, 32'({mem_read, mem_write}), 32'({e_read, e_write}));
      chk({t, ".mode"}, 32'(mem_mode), 32'(e_mode));
      chk({t, ".addr"}, 32'(mem_addr), 32'(e_addr));
      chk({t, ".wdata"}, mem_wdata, e_wdata);
      chk({t, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        if_req;
      logic [5:0]  if_addr;
      logic        d_req;
      logic        d_we;
      logic [1:0]  d_mode;
      logic [5:0]  d_addr;
      logic [31:0] d_wdata;
      logic        exp_if;
      logic        exp_read;
      logic        exp_write;
      logic [1:0]  exp_mode;
      logic [5:0]  exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1, 6'h04, 0, 0, MODE_WORD, 6'h00, 32'h0,         1, 1, 0, MODE_WORD, 6'h04, 32'h0,         32'h0000_0013};
      vecs[1] = '{0, 6'h00, 1, 1, MODE_WORD, 6'h08, 32'h0000_000F, 0, 0, 1, MODE_WORD, 6'h08, 32'h0000_000F, 32'h0};
      vecs[2] = '{0, 6'h00, 1, 0, MODE_WORD, 6'h08, 32'h0000_1234, 0, 1, 0, MODE_WORD, 6'h08, 32'h0000_1234, 32'h0000_000F};
`ifdef MEM_ARB_RR_EN
      vecs[3] = '{1, 6'h01, 1, 0, MODE_HALF, 6'h02, 32'h0,         1, 1, 0, MODE_WORD, 6'h01, 32'h0,         32'h1000_0001};
`else
      vecs[3] = '{1, 6'h01, 1, 0, MODE_HALF, 6'h02, 32'h0,         0, 1, 0, MODE_HALF, 6'h02, 32'h0,         32'h1000_0002};
`endif
      vecs[4] = '{0, 6'h00, 1, 0, MODE_BYTE, 6'h3F, 32'h0,         0, 1, 0, MODE_BYTE, 6'h3F, 32'h0,         32'h1000_003F};
      vecs[5] = '{1, 6'h3F, 0, 0, MODE_WORD, 6'h00, 32'h0,         1, 1, 0, MODE_WORD, 6'h3F, 32'h0,         32'h1000_003F};
      vecs[6] = '{0, 6'h00, 1, 1, MODE_HALF, 6'h00, 32'hFFFF_FFFF, 0, 0, 1, MODE_HALF, 6'h00, 32'hFFFF_FFFF, 32'h1000_003F};
      vecs[7] = '{0, 6'h00, 1, 0, MODE_WORD, 6'h00, 32'h0,         0, 1, 0, MODE_WORD, 6'h00, 32'h0,         32'hFFFF_FFFF};

      // Reset state
      do_reset();
      chk("rst.gnt", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid}), 32'h0);
      chk("rst.mem", 32'({mem_read, mem_write, mem_mode, mem_addr}), 32'h0);
      chk("rst.rdata", if_rdata | d_rdata | mem_wdata, 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));

      // Table vectors: one transaction each from IDLE
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if_req = vecs[k].if_req; if_addr = vecs[k].if_addr;
         d_req = vecs[k].d_req; d_we = vecs[k].d_we; d_mode = vecs[k].d_mode;
         d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
         @(negedge clk);
         chk($sformatf("vec%0d.gnt", k), 32'({if_gnt, d_gnt}), 32'({vecs[k].exp_if, !vecs[k].exp_if}));
         chk($sformatf("vec%0d.rw", k), 32'({mem_read, mem_write}),
             32'({vecs[k].exp_read, vecs[k].exp_write}));
         chk($sformatf("vec%0d.mode", k), 32'(mem_mode), 32'(vecs[k].exp_mode));
         chk($sformatf("vec%0d.addr", k), 32'(mem_addr), 32'(vecs[k].exp_addr));
         chk($sformatf("vec%0d.wdata", k), mem_wdata, vecs[k].exp_wdata);
         chk($sformatf("vec%0d.busy", k), 32'(busy), 32'h1);
         idle_inputs();
         @(negedge clk);
         chk($sformatf("vec%0d.rvalid", k), 32'({if_rvalid, d_rvalid}),
             32'({vecs[k].exp_if, !vecs[k].exp_if}));
         chk($sformatf("vec%0d.rdata", k), vecs[k].exp_if ? if_rdata : d_rdata, vecs[k].exp_rdata);
         chk($sformatf("vec%0d.rw_off", k), 32'({mem_read, mem_write}), 32'h0);
      end

      // Both requesters held continuously: grant order and 2-cycle throughput
      do_reset();
      for (int s = 0; s < 12; s++) begin
`ifdef MEM_ARB_RR_EN
         exp_q.push_back((s % 2 == 0) ? 32'h2 : 32'h1);
`else
         exp_q.push_back((s % (STARVE + 1) == STARVE) ? 32'h2 : 32'h1);
`endif
      end
      @(negedge clk);
      if_req = 1; if_addr = 6'h05; d_req = 1; d_we = 0; d_mode = MODE_WORD; d_addr = 6'h06;
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         chk($sformatf("order%0d", s), 32'({if_gnt, d_gnt}), exp_q.pop_front());
         @(negedge clk);
         chk($sformatf("order%0d.resp", s), 32'({if_gnt, d_gnt, busy}), 32'h1);
      end
      idle_inputs();
      @(negedge clk);

      // Back-to-back D loads 0,1,2
      for (int a = 0; a < 3; a++) exp_q.push_back(init_word(a));
      d_req = 1; d_we = 0; d_addr = 6'h00;
      for (int a = 0; a < 3; a++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d.gnt", a), 32'(d_gnt), 32'h1);
         if (a == 2) d_req = 0;
         else d_addr = 6'(a + 1);
         @(negedge clk);
         chk($sformatf("b2b%0d.rvalid", a), 32'({d_gnt, d_rvalid}), 32'h1);
         chk($sformatf("b2b%0d.rdata", a), d_rdata, exp_q.pop_front());
      end
      @(negedge clk);

      // Reset asserted during ACCESS of a load
      d_req = 1; d_we = 0; d_addr = 6'h09;
      @(negedge clk);
      chk("rstmid.gnt", 32'(d_gnt), 32'h1);
      d_req = 0;
      #1 rst = 1'b0;
      #1;
      chk("rstmid.mem", 32'({mem_read, mem_write, mem_mode, mem_addr}), 32'h0);
      chk("rstmid.wdata", mem_wdata, 32'h0);
      chk("rstmid.busy", 32'(busy), 32'h0);
      chk("rstmid.state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rstmid.norv%0d", c), 32'({d_rvalid, if_rvalid, busy}), 32'h0);
      end

      // D pulse during an IF ACCESS, withdrawn before arbitration
      if_req = 1; if_addr = 6'h07;
      @(negedge clk);
      chk("pulse.ifgnt", 32'({if_gnt, d_gnt}), 32'h2);
      if_req = 0; d_req = 1; d_we = 0; d_addr = 6'h0A;
      @(negedge clk);
      chk("pulse.ifrv", 32'(if_rvalid), 32'h1);
      d_req = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("pulse.nodgnt%0d", c), 32'({d_gnt, d_rvalid, busy}), 32'h0);
      end

      // Randomized traffic against the reference model
      begin
         logic        if_hold, d_hold, r_we;
         logic [5:0]  r_if_addr, r_d_addr;
         logic [1:0]  r_mode;
         logic [31:0] r_wdata;
         if_hold = 0; d_hold = 0; r_we = 0; r_if_addr = '0; r_d_addr = '0;
         r_mode = MODE_WORD; r_wdata = '0;
         do_reset();
         model_reset();
         for (int c = 0; c < 3000; c++) begin
            if (e_if_gnt) if_hold = 0;
            if (e_d_gnt) d_hold = 0;
            if (if_hold && $urandom_range(0, 9) == 0) begin
               if_hold = 0;
            end else if (!if_hold && $urandom_range(0, 1) == 1) begin
               if_hold = 1;
               r_if_addr = 6'($urandom_range(0, 63));
            end
            if (d_hold && $urandom_range(0, 9) == 0) begin
               d_hold = 0;
            end else if (!d_hold && $urandom_range(0, 1) == 1) begin
               d_hold = 1;
               r_we = 1'($urandom_range(0, 1));
               r_mode = 2'($urandom_range(0, 2));
               r_d_addr = 6'($urandom_range(0, 63));
               r_wdata = $urandom;
            end
            if_req = if_hold; if_addr = r_if_addr;
            d_req = d_hold; d_we = r_we; d_mode = r_mode; d_addr = r_d_addr; d_wdata = r_wdata;
            model_edge();
            @(negedge clk);
            check_all("rnd");
         end
         idle_inputs();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
